// File: rtl/pulse_delay_multi.sv
// Multi-shot pulse delay: each input event re-emerges as a one-cycle pulse
// 'delay' clocks later, with up to DEPTH events tracked in independent slot timers.
module pulse_delay_multi #(
  parameter  int W     = 8,
  parameter  int DEPTH = 4,
  parameter  int EDGE  = 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_data,
  input  logic [W-1:0]  delay,
  input  logic          cancel,
  input  logic          clear_ovf,
  output logic          out_data,
  output logic          merged,
  output logic [CW-1:0] busy_count,
  output logic          overflow
);

  logic                    in_prev_q;
  logic [DEPTH-1:0]        active_q, active_d;
  logic [DEPTH-1:0][W-1:0] cnt_q, cnt_d;
  logic                    out_data_q, out_data_d;
  logic                    merged_q, merged_d;
  logic [CW-1:0]           busy_q, busy_d;
  logic                    overflow_q, overflow_d;

  logic                    evt;
  logic                    drop;
  logic                    alloc_done;
  logic [W-1:0]            load_val;
  logic [DEPTH-1:0]        expire;
  logic [CW-1:0]           n_exp;

  // delay=0 behaves as delay=1, so the loaded count saturates at zero
  assign load_val = (delay == '0) ? '0 : delay - W'(1);

  always_comb begin
    evt        = (EDGE != 0) ? (in_data & ~in_prev_q) : in_data;
    drop       = evt & (&active_q);
    active_d   = active_q;
    cnt_d      = cnt_q;
    expire     = '0;
    alloc_done = 1'b0;
    n_exp      = '0;
    busy_d     = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (active_q[i]) begin
        if (cnt_q[i] == '0) begin
          expire[i]   = 1'b1;
          active_d[i] = 1'b0;
        end else begin
          cnt_d[i] = cnt_q[i] - W'(1);
        end
      end
    end

    // Allocation looks at the pre-edge state, so a slot freed this edge stays idle
    for (int i = 0; i < DEPTH; i++) begin
      if (evt && !alloc_done && !active_q[i]) begin
        active_d[i] = 1'b1;
        cnt_d[i]    = load_val;
        alloc_done  = 1'b1;
      end
    end

    if (cancel) begin
      active_d = '0;
      cnt_d    = '0;
    end

    for (int i = 0; i < DEPTH; i++) begin
      n_exp  = n_exp + CW'(expire[i]);
      busy_d = busy_d + CW'(active_d[i]);
    end

    out_data_d = (n_exp != '0) & ~cancel;
    merged_d   = (n_exp > CW'(1)) & ~cancel;

    if (drop && !cancel)
      overflow_d = 1'b1;
    else if (clear_ovf)
      overflow_d = 1'b0;
    else
      overflow_d = overflow_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_prev_q  <= 1'b0;
      active_q   <= '0;
      cnt_q      <= '0;
      out_data_q <= 1'b0;
      merged_q   <= 1'b0;
      busy_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      in_prev_q  <= in_data;
      active_q   <= active_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      merged_q   <= merged_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_data   = out_data_q;
  assign merged     = merged_q;
  assign busy_count = busy_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_delay_multi.sv
// Directed-vector bench for pulse_delay_multi: one EDGE=1 instance driven from a
// per-cycle vector table, plus an EDGE=0 instance for level-triggered events.
module tb_pulse_delay_multi;

  typedef struct {
    bit       rst;
    bit       din;
    bit [7:0] dly;
    bit       cnc;
    bit       clr;
    bit       out;
    bit       mrg;
    bit [2:0] busy;
    bit       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_data, cancel, clear_ovf;
  logic [7:0] delay;
  logic       out_data, merged, overflow;
  logic [2:0] busy_count;

  logic       in_data0, cancel0, clear_ovf0;
  logic [7:0] delay0;
  logic       out_data0, merged0, overflow0;
  logic [2:0] busy_count0;

  int checks   = 0;
  int failures = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pulse_delay_multi #(.W(8), .DEPTH(4), .EDGE(1)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .delay(delay),
    .cancel(cancel), .clear_ovf(clear_ovf), .out_data(out_data),
    .merged(merged), .busy_count(busy_count), .overflow(overflow));

  pulse_delay_multi #(.W(8), .DEPTH(4), .EDGE(0)) dut_lvl (
    .clk(clk), .reset(reset), .in_data(in_data0), .delay(delay0),
    .cancel(cancel0), .clear_ovf(clear_ovf0), .out_data(out_data0),
    .merged(merged0), .busy_count(busy_count0), .overflow(overflow0));

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  function automatic void a(input bit rst, input bit din, input bit [7:0] dly, input bit cnc,
                            input bit clr, input bit out, input bit mrg, input bit [2:0] busy,
                            input bit ovf);
    vec_t v;
    v.rst = rst; v.din = din; v.dly = dly; v.cnc = cnc; v.clr = clr;
    v.out = out; v.mrg = mrg; v.busy = busy; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  function automatic void an(input int n, input bit din, input bit [7:0] dly, input bit out,
                             input bit [2:0] busy, input bit ovf);
    for (int i = 0; i < n; i++) a(0, din, dly, 0, 0, out, 0, busy, ovf);
  endfunction

  // Called at a negedge: optional reset pulse, drive inputs, clock once, compare.
  task automatic apply(input vec_t v, input int idx);
    if (v.rst) begin
      reset = 1'b1;
      #1;
      reset = 1'b0;
    end
    in_data   = v.din;
    delay     = v.dly;
    cancel    = v.cnc;
    clear_ovf = v.clr;
    @(posedge clk);
    @(negedge clk);
    chk("out_data",   idx, {7'd0, out_data}, {7'd0, v.out});
    chk("merged",     idx, {7'd0, merged},   {7'd0, v.mrg});
    chk("busy_count", idx, {5'd0, busy_count}, {5'd0, v.busy});
    chk("overflow",   idx, {7'd0, overflow}, {7'd0, v.ovf});
  endtask

  function automatic vec_t mk(input bit rst, input bit din, input bit [7:0] dly,
                              input bit out, input bit [2:0] busy);
    vec_t v;
    v.rst = rst; v.din = din; v.dly = dly; v.cnc = 0; v.clr = 0;
    v.out = out; v.mrg = 0; v.busy = busy; v.ovf = 0;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit       lvl_in[6]   = '{1, 1, 1, 0, 0, 0};
    bit       lvl_out[6]  = '{0, 0, 1, 1, 1, 0};
    bit [2:0] lvl_busy[6] = '{1, 2, 2, 1, 0, 0};

    // single event, delay 5, rising at edge 10 and held high
    a(1, 0, 0, 0, 0, 0, 0, 0, 0); an(9, 0, 0, 0, 0, 0);
    a(0, 1, 5, 0, 0, 0, 0, 1, 0); an(4, 1, 5, 0, 1, 0);
    a(0, 1, 5, 0, 0, 1, 0, 0, 0); a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // pipelined: events at 0,2,4 with delay 10
    a(1, 1, 10, 0, 0, 0, 0, 1, 0); an(1, 0, 10, 0, 1, 0);
    an(1, 1, 10, 0, 2, 0); an(1, 0, 10, 0, 2, 0);
    an(1, 1, 10, 0, 3, 0); an(5, 0, 10, 0, 3, 0);
    an(1, 0, 0, 1, 2, 0); an(1, 0, 0, 0, 2, 0);
    an(1, 0, 0, 1, 1, 0); an(1, 0, 0, 0, 1, 0);
    an(1, 0, 0, 1, 0, 0); an(1, 0, 0, 0, 0, 0);
    // merge: delay 6 at edge 0, delay 4 at edge 2
    a(1, 1, 6, 0, 0, 0, 0, 1, 0); an(1, 0, 6, 0, 1, 0);
    an(1, 1, 4, 0, 2, 0); an(3, 0, 4, 0, 2, 0);
    a(0, 0, 0, 0, 0, 1, 1, 0, 0); an(1, 0, 0, 0, 0, 0);
    // overflow: 5 events at delay 20, 6th dropped while clear_ovf asserted
    a(1, 1, 20, 0, 0, 0, 0, 1, 0); an(1, 0, 20, 0, 1, 0);
    an(1, 1, 20, 0, 2, 0); an(1, 0, 20, 0, 2, 0);
    an(1, 1, 20, 0, 3, 0); an(1, 0, 20, 0, 3, 0);
    an(1, 1, 20, 0, 4, 0); an(1, 0, 20, 0, 4, 0);
    an(1, 1, 20, 0, 4, 1); an(1, 0, 20, 0, 4, 1);
    a(0, 1, 20, 0, 1, 0, 0, 4, 1); an(9, 0, 20, 0, 4, 1);
    an(1, 0, 0, 1, 3, 1); an(1, 0, 0, 0, 3, 1);
    an(1, 0, 0, 1, 2, 1); an(1, 0, 0, 0, 2, 1);
    an(1, 0, 0, 1, 1, 1); an(1, 0, 0, 0, 1, 1);
    an(1, 0, 0, 1, 0, 1);
    a(0, 0, 0, 0, 1, 0, 0, 0, 0); an(1, 0, 0, 0, 0, 0);
    // cancel one edge before first expiry, with an event on the same edge
    a(1, 1, 10, 0, 0, 0, 0, 1, 0); an(1, 0, 10, 0, 1, 0);
    an(1, 1, 10, 0, 2, 0); an(1, 0, 10, 0, 2, 0);
    an(1, 1, 10, 0, 3, 0); an(4, 0, 10, 0, 3, 0);
    a(0, 1, 10, 1, 0, 0, 0, 0, 0); an(6, 0, 0, 0, 0, 0);
    // slot freed at edge 8 is not reusable at edge 8, but is at edge 10
    a(1, 1, 8, 0, 0, 0, 0, 1, 0); an(1, 0, 8, 0, 1, 0);
    an(1, 1, 20, 0, 2, 0); an(1, 0, 20, 0, 2, 0);
    an(1, 1, 20, 0, 3, 0); an(1, 0, 20, 0, 3, 0);
    an(1, 1, 20, 0, 4, 0); an(1, 0, 20, 0, 4, 0);
    an(1, 1, 20, 1, 3, 1); an(1, 0, 20, 0, 3, 1);
    an(1, 1, 3, 0, 4, 1); an(2, 0, 3, 0, 4, 1);
    an(1, 0, 0, 1, 3, 1);
    // cancel on the edge a slot is due; in_data held high afterwards
    a(1, 1, 2, 0, 0, 0, 0, 1, 0); an(1, 0, 2, 0, 1, 0);
    a(0, 1, 2, 1, 0, 0, 0, 0, 0); an(1, 1, 2, 0, 0, 0);
    an(2, 0, 0, 0, 0, 0);
    // delay 0 behaves as 1
    a(1, 1, 0, 0, 0, 0, 0, 1, 0); an(1, 0, 0, 1, 0, 0); an(1, 0, 0, 0, 0, 0);

    reset = 1'b1; in_data = 0; delay = 0; cancel = 0; clear_ovf = 0;
    in_data0 = 0; delay0 = 8'd2; cancel0 = 0; clear_ovf0 = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_out",  -1, {7'd0, out_data}, 8'd0);
    chk("rst_mrg",  -1, {7'd0, merged}, 8'd0);
    chk("rst_busy", -1, {5'd0, busy_count}, 8'd0);
    chk("rst_ovf",  -1, {7'd0, overflow}, 8'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // delay 255: pulse exactly 255 clocks after the event
    apply(mk(1, 1, 8'd255, 0, 1), 1000);
    for (int i = 1; i < 255; i++) apply(mk(0, 0, 8'd0, 0, 1), 1000 + i);
    apply(mk(0, 0, 8'd0, 1, 0), 1255);
    apply(mk(0, 0, 8'd0, 0, 0), 1256);

    // reset mid-flight while a pulse is showing and another slot is pending
    apply(mk(1, 1, 8'd4, 0, 1), 2000);
    apply(mk(0, 0, 8'd4, 0, 1), 2001);
    apply(mk(0, 1, 8'd1, 0, 2), 2002);
    apply(mk(0, 0, 8'd0, 1, 1), 2003);
    reset = 1'b1;
    #1;
    chk("async_rst_out",  2004, {7'd0, out_data}, 8'd0);
    chk("async_rst_busy", 2004, {5'd0, busy_count}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) apply(mk(0, 0, 8'd0, 0, 0), 2005 + i);

    // level-triggered instance: in_data high for 3 cycles at delay 2
    reset = 1'b1;
    #1;
    reset = 1'b0;
    in_data = 0;
    for (int i = 0; i < 6; i++) begin
      in_data0 = lvl_in[i];
      @(posedge clk);
      @(negedge clk);
      chk("lvl_out",  3000 + i, {7'd0, out_data0}, {7'd0, lvl_out[i]});
      chk("lvl_busy", 3000 + i, {5'd0, busy_count0}, {5'd0, lvl_busy[i]});
      chk("lvl_mrg",  3000 + i, {7'd0, merged0}, 8'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
